// File: rtl/iccm_boot.sv
// ICCM read responder with a byte-stream boot loader.
// Bytes are packed little-endian into words, and the core is held in reset until the last byte is accepted.
module iccm_boot #(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       iccm_rd_addr,
  input  logic              iccm_rd_en,
  output logic [31:0]       iccm_rd_data,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              core_rst_n,
  output logic              ld_err,
  output logic [ADDR_W:0]   ld_words
);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wptr_q;
  logic [1:0]        cnt_q;
  logic [23:0]       buf_q;
  logic              err_q;
  logic [31:0]       rd_data_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              full;
  logic              word_done;
  logic              we;
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] rd_idx;
  logic              unused_addr_bits;

  assign accept    = ld_valid && (state_q == S_LOAD);
  assign full      = (wptr_q == (ADDR_W+1)'(DEPTH_WORDS));
  assign word_done = accept && ((cnt_q == 2'd3) || ld_last);
  assign we        = word_done && !full;
  assign rd_idx    = iccm_rd_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{iccm_rd_addr[31:ADDR_W+2], iccm_rd_addr[1:0]};

  // Unfilled upper bytes of a short final word come out as zero.
  always_comb begin
    wdata = '0;
    case (cnt_q)
      2'd0: wdata = {24'h0, ld_byte};
      2'd1: wdata = {16'h0, ld_byte, buf_q[7:0]};
      2'd2: wdata = {8'h0, ld_byte, buf_q[15:0]};
      default: wdata = {ld_byte, buf_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (accept && ld_last) state_d = S_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (accept) begin
        if (word_done) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 2'd1;
          case (cnt_q)
            2'd0:    buf_q[7:0]   <= ld_byte;
            2'd1:    buf_q[15:8]  <= ld_byte;
            default: buf_q[23:16] <= ld_byte;
          endcase
        end
      end
      if (we) wptr_q <= wptr_q + 1'b1;
      if (word_done && full) err_q <= 1'b1;
      if (iccm_rd_en) rd_data_q <= mem[rd_idx];
    end
  end

  // Array has no reset so an image survives rst_n; read-before-write on collision.
  always_ff @(posedge clk) begin
    if (we) mem[wptr_q[ADDR_W-1:0]] <= wdata;
  end

  assign iccm_rd_data = rd_data_q;
  assign ld_ready     = (state_q == S_LOAD);
  assign core_rst_n   = (state_q == S_RUN);
  assign ld_err       = err_q;
  assign ld_words     = wptr_q;

endmodule

// File: doc/iccm_boot.md
# iccm_boot

Instruction-memory responder with an integrated byte-stream boot loader. It services the instruction fetch unit's ICCM read port (address/enable in, data out) with fixed one-cycle latency. Before that, it accepts a program image as a byte stream from a host or debug link, packs it into 32-bit words, and holds the core in reset until loading finishes. It sits between the core top level's `iccm_*` ports and the storage array, replacing a bare memory model.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the array. Must be a power of two, minimum 4.
- `ADDR_W`, default log2(`DEPTH_WORDS`): word-index width. Derived; not overridden.

- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `iccm_rd_addr`  in  32  fetch byte address.
- `iccm_rd_en`  in  1  fetch read request.
- `iccm_rd_data`  out  32  fetch read data.
- `ld_valid`  in  1  load byte valid.
- `ld_byte`  in  8  load byte.
- `ld_last`  in  1  marks the final byte of the image; qualified by `ld_valid`.
- `ld_ready`  out  1  loader can accept a byte.
- `core_rst_n`  out  1  active-low reset to the core; held low while loading.
- `ld_err`  out  1  sticky: image overflowed the array.
- `ld_words`  out  `ADDR_W`+1  count of words written by the current load.

## Operation
- **States.** Two states, LOAD and RUN. Reset enters LOAD.
- **Byte acceptance.** A byte is accepted on a rising edge where `ld_valid` and `ld_ready` are both 1.
- **LOAD behaviour.**
  - `ld_ready` = 1 and `core_rst_n` = 0.
  - Bytes pack little-endian. The first accepted byte goes to bits [7:0], the fourth to [31:24].
  - Internal state: a 2-bit byte counter and a 24-bit holding buffer.
- **Word write.** On acceptance of the 4th byte of a word:
  - word {byte, buffer} is written to `array[wptr]`;
  - `wptr` increments;
  - the byte counter wraps to 0.
  - This all happens on the same edge.
- **`ld_last` handling.** On acceptance of a byte with `ld_last` = 1:
  - If the byte counter is not 3, the partial word is written with its unfilled upper bytes zeroed.
  - If it completes a word exactly, there is no extra write.
  - The state moves to RUN on the same edge.
- **Overflow.**
  - A byte that would complete a word while `wptr` = `DEPTH_WORDS` is discarded, with no write, and `ld_err` is set to 1.
  - `ld_ready` stays 1 so the host can drain the rest of the image.
  - `ld_last` still moves the state to RUN.
- **RUN behaviour.**
  - `ld_ready` = 0 and `core_rst_n` = 1.
  - `ld_valid` is ignored.
  - RUN is left only by `rst_n`.
- **`ld_words`.** Equals `wptr`: the number of words written, including a padded partial word. It saturates at `DEPTH_WORDS`.
- **Fetch addressing.** Word index = `iccm_rd_addr[ADDR_W+1:2]`.
  - Bits [1:0] are ignored; misaligned addresses are not flagged.
  - Upper bits are ignored, so addresses alias modulo the array size.
- **Fetch servicing.** Fetches are serviced in both states.
  - `iccm_rd_en` = 1 at edge N: `iccm_rd_data` = `array[index]` after edge N.
  - `iccm_rd_en` = 0: `iccm_rd_data` holds its previous value.
- **Read/write collision.** A fetch and a load write to the same word on the same edge return the old array contents (read-before-write).
- **Array contents.** The array is not reset. Contents survive `rst_n`.

## Timing
- **Reset values** (`rst_n` low at an edge):
  - state = LOAD, `wptr` = 0, byte counter = 0, buffer = 0;
  - `iccm_rd_data` = 0, `ld_ready` = 1, `core_rst_n` = 0, `ld_err` = 0, `ld_words` = 0.
- **Fetch latency.** Exactly 1 cycle from `iccm_rd_en` sample to data. Back-to-back fetches give one word per cycle. There is no stall or valid signal.
- **Load throughput.** One byte per cycle; `ld_ready` never drops inside LOAD. A word write lands on the 4th byte's acceptance edge.
- **Core release.** All outputs are registered. `core_rst_n` rises and `ld_ready` falls on the edge that accepts `ld_last`. A core fetch the following cycle sees the final word.
- **Reset mid-load.** Reset returns the block to LOAD with `wptr`/counter cleared and `core_rst_n` = 0. Words already written remain in the array; a new load overwrites from word 0.
- **Reset in RUN.** Reset also returns to LOAD and reasserts `core_rst_n`, so a new image is required.

## Test plan
- **Reset.** Hold `rst_n` low 2 cycles, then release. Required: `core_rst_n` = 0, `ld_ready` = 1, `iccm_rd_data` = 0x00000000, `ld_err` = 0, `ld_words` = 0.
- **Full-word load.** Stream bytes 13 05 10 00 93 05 20 00 on consecutive cycles, `ld_last` on the 8th. Required: `core_rst_n` = 1 after that edge and `ld_words` = 2. Then fetch addr 0x0 followed by 0x4 (which aliases with 0x6): `iccm_rd_data` = 0x00100513, then 0x00200593, each 1 cycle after request.
- **Partial last word.** Load AA BB CC DD 11 22 with `ld_last` on 22. Required: word1 = 0x00002211, `ld_words` = 2.
- **Overflow** (`DEPTH_WORDS` = 4). Load 20 bytes 0x00..0x13, `ld_last` on the last. Required:
  - `ld_err` = 1, `ld_words` = 4;
  - word3 = 0x0F0E0D0C;
  - fetch 0x10 aliases to word0 = 0x03020100;
  - state is RUN.
- **Fetch hold and collision.** Issue fetches at 0x0, 0x4, 0x8, then `iccm_rd_en` = 0 for 3 cycles. Required: data updates each cycle, then holds the word-2 value. A same-edge fetch and load write to word 0 returns the old value.
- **Mid-load reset.** Pulse `rst_n` after 5 bytes, then load 4 bytes 01 02 03 04 with `ld_last`. Required: word0 = 0x04030201, `ld_words` = 1, `core_rst_n` = 1.
